wishbone_arbiter2: RTL and testbench

//  Two-master, one-slave Wishbone arbiter sharing the register-file slave between the Modbus

---
 rtl/wishbone_arbiter2_pkg.sv | 20 ++
 rtl/wishbone_arbiter2_watchdog.sv | 38 +++
 rtl/wishbone_arbiter2.sv | 142 ++++++++++++++
 tb/tb_wishbone_arbiter2.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_arbiter2_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wishbone_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arbState_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // One-hot grant vector for a master index (0 or 1).
  function automatic logic [1:0] gntFor(input logic owner);
    return owner ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/wishbone_arbiter2_watchdog.sv
// Bus watchdog: counts consecutive stalled strobe cycles of the current owner
// and flags the cycle in which the stall limit is reached.
module wishbone_arbiter2_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic stb,
  input  logic ack,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_OK  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;
  logic          stall;

  // A stalled cycle: owner strobing, slave silent. Ack in the same cycle wins.
  always_comb begin
    stall   = active & stb & ~ack;
    timeout = stall & (count == LAST_OK);
  end

  // Count stalled cycles; any break in the stall or the abort itself clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!stall || timeout) begin
      count <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/wishbone_arbiter2.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for a whole
// cyc burst, with a watchdog that aborts hung cycles.
module wishbone_arbiter2
  import wishbone_arbiter2_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0]    m0_dat_i,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  output logic [DATA_WIDTH-1:0]    m0_dat_o,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  input  logic [ADDRESS_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0]    m1_dat_i,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  output logic [DATA_WIDTH-1:0]    m1_dat_o,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic [ADDRESS_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0]    s_dat_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  input  logic [DATA_WIDTH-1:0]    s_dat_i,
  input  logic                     s_ack_i,
  output logic [1:0]               gnt_o
);

  arbState_t state;
  logic      last;      // index of the most recent owner; also the owner while in ABORT
  logic      granted;
  logic      ownerCyc;
  logic      ownerStb;
  logic      abortCyc;
  logic      timeout;

  // Owner-side request lines, zero when nobody holds the bus.
  always_comb begin
    granted  = (state == GNT0) || (state == GNT1);
    ownerCyc = (state == GNT0) ? m0_cyc_i : (state == GNT1) ? m1_cyc_i : 1'b0;
    ownerStb = (state == GNT0) ? m0_stb_i : (state == GNT1) ? m1_stb_i : 1'b0;
    abortCyc = last ? m1_cyc_i : m0_cyc_i;
  end

  wishbone_arbiter2_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .active (granted),
    .stb    (ownerCyc & ownerStb),
    .ack    (s_ack_i),
    .timeout(timeout)
  );

  // Arbitration FSM: grant, hold for the burst, release or abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt_o <= GNT_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= GNT0;
            last  <= 1'b0;
            gnt_o <= gntFor(1'b0);
          end else if (m1_cyc_i) begin
            state <= GNT1;
            last  <= 1'b1;
            gnt_o <= gntFor(1'b1);
          end
        end
        GNT0, GNT1: begin
          if (timeout) begin
            state <= ABORT;
            gnt_o <= GNT_NONE;
          end else if (!ownerCyc) begin
            state <= IDLE;
            gnt_o <= GNT_NONE;
          end
        end
        ABORT: begin
          if (!abortCyc) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= GNT_NONE;
        end
      endcase
    end
  end

  // Owner-path bus mux; everything idles at zero outside a grant.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (state == GNT0) begin
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      m0_ack_o = s_ack_i;
      m0_err_o = timeout;
    end else if (state == GNT1) begin
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      m1_ack_o = s_ack_i;
      m1_err_o = timeout;
    end
    if (granted) begin
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Self-checking bench for wishbone_arbiter2 (watchdog limit 8 cycles).
module tb_wishbone_arbiter2;

  logic        clk;
  logic        rst;
  logic [23:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [1:0]  gnt_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        m;
    logic [23:0] adr;
    logic [31:0] wd;
    logic        we;
    int          dly;
    logic [31:0] rd;
    logic [1:0]  expGnt;
    logic [31:0] expRd;
  } vec_t;

  typedef struct {
    logic [1:0]  gnt;
    logic [23:0] adr;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
  } exp_t;

  vec_t vecs[5];
  exp_t sbq[$];

  wishbone_arbiter2 #(
    .ADDRESS_WIDTH (24),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_we_i(m0_we_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_we_i(m1_we_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drvM(input logic m, input logic cyc, input logic [23:0] adr,
                      input logic [31:0] wd, input logic we);
    if (!m) begin
      m0_cyc_i = cyc; m0_stb_i = cyc; m0_adr_i = adr; m0_dat_i = wd; m0_we_i = we;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = cyc; m1_adr_i = adr; m1_dat_i = wd; m1_we_i = we;
    end
  endtask

  function automatic logic ackOf(input logic m);
    return m ? m1_ack_o : m0_ack_o;
  endfunction

  function automatic logic errOf(input logic m);
    return m ? m1_err_o : m0_err_o;
  endfunction

  function automatic logic [31:0] datOf(input logic m);
    return m ? m1_dat_o : m0_dat_o;
  endfunction

  // Pop the expected transaction and compare it against the acked beat of master m.
  task automatic checkAck(input logic m);
    exp_t e;
    if (sbq.size() == 0) begin
      chk1("sb_underflow", 1'b1, 1'b0);
    end else begin
      e = sbq.pop_front();
      chk1("ack_owner", ackOf(m), 1'b1);
      chk1("ack_other", ackOf(~m), 1'b0);
      chk1("err_on_ack", errOf(m), 1'b0);
      chk("rdata", datOf(m), e.rd);
      chk("s_adr", 32'(s_adr_o), 32'(e.adr));
      chk("s_wdata", s_dat_o, e.wd);
      chk1("s_we", s_we_o, e.we);
      chk("gnt_at_ack", 32'(gnt_o), 32'(e.gnt));
    end
  endtask

  // One single-beat transaction from IDLE back to IDLE.
  task automatic runVec(input vec_t v);
    exp_t e;
    drvM(v.m, 1'b1, v.adr, v.wd, v.we);
    #1;
    chk1("latency_idle", s_cyc_o, 1'b0);
    e.gnt = v.expGnt; e.adr = v.adr; e.wd = v.wd; e.we = v.we; e.rd = v.expRd;
    sbq.push_back(e);
    tick();
    chk1("s_cyc_granted", s_cyc_o, 1'b1);
    chk("gnt_granted", 32'(gnt_o), 32'(v.expGnt));
    for (int i = 0; i < v.dly; i++) begin
      chk1("ack_wait", ackOf(v.m), 1'b0);
      chk1("err_wait", errOf(v.m), 1'b0);
      tick();
    end
    s_ack_i = 1'b1;
    s_dat_i = v.rd;
    #1;
    checkAck(v.m);
    tick();
    s_ack_i = 1'b0;
    drvM(v.m, 1'b0, v.adr, v.wd, v.we);
    #1;
    chk1("ack_pulse_end", ackOf(v.m), 1'b0);
    chk1("s_cyc_release", s_cyc_o, 1'b0);
    tick();
    chk("gnt_idle", 32'(gnt_o), 32'(2'b00));
  endtask

  initial begin
    vecs[0] = '{m: 1'b0, adr: 24'h000010, wd: 32'h0, we: 1'b0, dly: 2,
                rd: 32'hDEADBEEF, expGnt: 2'b01, expRd: 32'hDEADBEEF};
    vecs[1] = '{m: 1'b1, adr: 24'hABCDEF, wd: 32'h12345678, we: 1'b1, dly: 0,
                rd: 32'h0, expGnt: 2'b10, expRd: 32'h0};
    vecs[2] = '{m: 1'b1, adr: 24'h000001, wd: 32'h0, we: 1'b0, dly: 3,
                rd: 32'hCAFEF00D, expGnt: 2'b10, expRd: 32'hCAFEF00D};
    vecs[3] = '{m: 1'b0, adr: 24'hFFFFFF, wd: 32'hA5A5A5A5, we: 1'b1, dly: 7,
                rd: 32'h0F0F0F0F, expGnt: 2'b01, expRd: 32'h0F0F0F0F};
    vecs[4] = '{m: 1'b0, adr: 24'h800000, wd: 32'h5A5A5A5A, we: 1'b0, dly: 1,
                rd: 32'h13579BDF, expGnt: 2'b01, expRd: 32'h13579BDF};

    // Reset held with busy inputs: every output must stay zero.
    rst = 1'b0;
    drvM(1'b0, 1'b1, 24'h123456, 32'h11111111, 1'b1);
    drvM(1'b1, 1'b1, 24'h654321, 32'h22222222, 1'b1);
    s_ack_i = 1'b1;
    s_dat_i = 32'hFFFFFFFF;
    tick();
    tick();
    chk1("rst_s_cyc", s_cyc_o, 1'b0);
    chk1("rst_s_stb", s_stb_o, 1'b0);
    chk("rst_s_adr", 32'(s_adr_o), 32'h0);
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk1("rst_m0_ack", m0_ack_o, 1'b0);
    chk("rst_m0_dat", m0_dat_o, 32'h0);
    drvM(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    drvM(1'b1, 1'b0, 24'h0, 32'h0, 1'b0);
    s_ack_i = 1'b0;
    s_dat_i = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single-beat transactions from the vector table.
    for (int i = 0; i < 5; i++) runVec(vecs[i]);

    // Simultaneous requests, four back-to-back bursts: grants alternate 0,1,0,1.
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    drvM(1'b0, 1'b1, 24'h0000A0, 32'h0, 1'b0);
    drvM(1'b1, 1'b1, 24'h0000B0, 32'h0, 1'b0);
    tick();
    for (int b = 0; b < 4; b++) begin
      logic o;
      o = b[0];
      chk("rr_gnt", 32'(gnt_o), 32'(o ? 2'b10 : 2'b01));
      chk("rr_adr", 32'(s_adr_o), o ? 32'h0000B0 : 32'h0000A0);
      s_ack_i = 1'b1;
      s_dat_i = 32'(b);
      #1;
      chk1("rr_ack_owner", ackOf(o), 1'b1);
      chk1("rr_ack_other", ackOf(~o), 1'b0);
      tick();
      s_ack_i = 1'b0;
      drvM(o, 1'b0, o ? 24'h0000B0 : 24'h0000A0, 32'h0, 1'b0);
      #1;
      chk1("rr_drop", s_cyc_o, 1'b0);
      tick();
      chk("rr_idle_gap", 32'(gnt_o), 32'h0);
      chk1("rr_idle_cyc", s_cyc_o, 1'b0);
      drvM(o, b < 2, o ? 24'h0000B0 : 24'h0000A0, 32'h0, 1'b0);
      tick();
    end
    drvM(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    drvM(1'b1, 1'b0, 24'h0, 32'h0, 1'b0);
    tick();
    tick();

    // m1 three-beat burst, ack every second cycle, m0 requests mid-burst.
    drvM(1'b1, 1'b1, 24'h000300, 32'h0, 1'b0);
    tick();
    for (int c = 1; c <= 6; c++) begin
      exp_t e;
      if (c == 3) drvM(1'b0, 1'b1, 24'h000400, 32'h0, 1'b0);
      s_ack_i = (c % 2 == 0);
      s_dat_i = 32'h1000 + 32'(c);
      if (c % 2 == 0) begin
        e.gnt = 2'b10; e.adr = 24'h000300; e.wd = 32'h0; e.we = 1'b0;
        e.rd = 32'h1000 + 32'(c);
        sbq.push_back(e);
      end
      #1;
      chk("burst_gnt", 32'(gnt_o), 32'(2'b10));
      chk1("burst_m0_ack", m0_ack_o, 1'b0);
      if (c % 2 == 0) checkAck(1'b1);
      else chk1("burst_no_ack", m1_ack_o, 1'b0);
      tick();
    end
    s_ack_i = 1'b0;
    drvM(1'b1, 1'b0, 24'h000300, 32'h0, 1'b0);
    #1;
    chk1("burst_drop", s_cyc_o, 1'b0);
    chk("burst_gnt_hold", 32'(gnt_o), 32'(2'b10));
    tick();
    chk("burst_gap", 32'(gnt_o), 32'h0);
    tick();
    chk("burst_m0_gnt", 32'(gnt_o), 32'(2'b01));
    chk("burst_m0_adr", 32'(s_adr_o), 32'h000400);
    drvM(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    tick();
    tick();

    // Ack on the 8th stalled cycle beats the timeout; then a full timeout.
    drvM(1'b0, 1'b1, 24'h000500, 32'hBADC0DE5, 1'b1);
    tick();
    for (int k = 1; k <= 7; k++) begin
      chk1("wd_pre_err", m0_err_o, 1'b0);
      tick();
    end
    s_ack_i = 1'b1;
    s_dat_i = 32'h600DF00D;
    #1;
    chk1("wd_ack_wins_ack", m0_ack_o, 1'b1);
    chk1("wd_ack_wins_err", m0_err_o, 1'b0);
    tick();
    s_ack_i = 1'b0;
    #1;
    chk1("wd_stay_cyc", s_cyc_o, 1'b1);
    chk("wd_stay_gnt", 32'(gnt_o), 32'(2'b01));
    for (int k = 1; k <= 7; k++) begin
      chk1("wd_stall_err", m0_err_o, 1'b0);
      tick();
    end
    chk1("wd_err_pulse", m0_err_o, 1'b1);
    chk1("wd_err_other", m1_err_o, 1'b0);
    chk1("wd_cyc_at_err", s_cyc_o, 1'b1);
    tick();
    chk1("wd_abort_cyc", s_cyc_o, 1'b0);
    chk1("wd_abort_stb", s_stb_o, 1'b0);
    chk1("wd_err_once", m0_err_o, 1'b0);
    s_ack_i = 1'b1;
    #1;
    chk1("wd_late_ack", m0_ack_o, 1'b0);
    tick();
    chk1("wd_abort_hold", s_cyc_o, 1'b0);
    s_ack_i = 1'b0;
    drvM(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    tick();

    // m1 granted after abort clears, reset mid-burst, both request afterwards.
    drvM(1'b1, 1'b1, 24'h000700, 32'h0, 1'b0);
    tick();
    chk("post_abort_gnt", 32'(gnt_o), 32'(2'b10));
    s_ack_i = 1'b1;
    #1;
    chk1("pre_rst_ack", m1_ack_o, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("async_rst_cyc", s_cyc_o, 1'b0);
    chk("async_rst_gnt", 32'(gnt_o), 32'h0);
    chk1("async_rst_ack", m1_ack_o, 1'b0);
    s_ack_i = 1'b0;
    drvM(1'b0, 1'b1, 24'h000800, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_first_gnt", 32'(gnt_o), 32'(2'b01));
    chk("rst_first_adr", 32'(s_adr_o), 32'h000800);
    chk("sb_left", 32'(sbq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
